// File: rtl/pow_res_fifo.sv
// Buffers the power unit's unstallable result stream behind a valid/ready consumer; 1-cycle write-to-read, FWFT head.
// Backpressure: out_rdy stalls the head only; a result arriving while full with no pop is dropped and flags sticky overflow.
module pow_res_fifo #(
    parameter int w     = 8,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    input  logic [w-1:0]           in_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [w-1:0]           out_data,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [$clog2(depth):0] count
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = (aw + 1)'(depth);

    logic [w-1:0]  mem_q [depth];
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, push;

    always_comb begin
        pop        = out_vld & out_rdy;
        // When full, a simultaneous pop frees the slot the push lands in.
        push       = in_vld & (~full | pop);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_vld & full & ~pop);
        if (pop)  rd_ptr_d = rd_ptr_q + aw'(1);
        if (push) wr_ptr_d = wr_ptr_q + aw'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (aw + 1)'(1);
            2'b01:   count_d = count_q - (aw + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == full_cnt);
    assign out_vld  = ~empty;
    assign out_data = mem_q[rd_ptr_q];
    assign overflow = overflow_q;
    assign count    = count_q;
endmodule

// File: tb/tb_pow_res_fifo.sv
// Directed and random traffic against a queue-based model of the result FIFO.
module tb_pow_res_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         ovf;

    pow_res_fifo #(.w(8), .depth(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_vld"},  {31'b0, out_vld},  {31'b0, q.size() != 0});
        chk({tag, ".empty"},    {31'b0, empty},    {31'b0, q.size() == 0});
        chk({tag, ".full"},     {31'b0, full},     {31'b0, q.size() == DEPTH});
        chk({tag, ".count"},    {29'b0, count},    q.size());
        chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, ovf});
        if (q.size() != 0) chk({tag, ".out_data"}, {24'b0, out_data}, {24'b0, q[0]});
    endtask

    // Called at a falling edge; applies inputs for one rising edge, then checks at the next falling edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic r);
        bit do_pop, do_push;
        in_vld  = v;
        in_data = v ? d : 8'hxx;
        out_rdy = r;
        do_pop  = r && (q.size() > 0);
        do_push = v && ((q.size() < DEPTH) || do_pop);
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(d);
        if (v && !do_push) ovf = 1'b1;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all("reset_hold");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'd32; fill[1] = 8'd53; fill[2] = 8'd1; fill[3] = 8'd0;
        in_vld  = 1'b0;
        in_data = 8'h00;
        out_rdy = 1'b0;
        ovf     = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) step("idle", 1'b0, 8'h00, 1'b0);

        // single pass-through
        step("pass_push", 1'b1, 8'd243, 1'b1);
        step("pass_pop",  1'b0, 8'h00,  1'b1);

        // fill with backpressure, head must hold
        for (int i = 0; i < 4; i++) step("fill", 1'b1, fill[i], 1'b0);
        step("hold", 1'b0, 8'h00, 1'b0);
        step("hold", 1'b0, 8'h00, 1'b0);

        // overflow while full and stalled; AA must never surface
        step("ovf_push", 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 5; i++) step("drain", 1'b0, 8'h00, 1'b1);
        step("ovf_sticky", 1'b0, 8'h00, 1'b0);

        // full with simultaneous push/pop
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 8'h10 + 8'(i), 1'b0);
        step("full_pushpop", 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 5; i++) step("drain2", 1'b0, 8'h00, 1'b1);

        // stream across pointer wrap, then reset asynchronously with two entries held
        for (int i = 0; i < 10; i++) begin
            step("wrap_push", 1'b1, 8'h60 + 8'(i), 1'b0);
            step("wrap_pop",  1'b0, 8'h00, 1'b1);
        end
        step("pre_rst", 1'b1, 8'hC1, 1'b0);
        step("pre_rst", 1'b1, 8'hC2, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        ovf = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        check_all("async_rst_hold");
        rst_n = 1'b1;
        step("post_rst", 1'b0, 8'h00, 1'b1);

        // random traffic, including overflow and simultaneous push/pop at full
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0);
        end
        for (int i = 0; i < 6; i++) step("rand_drain", 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
